// File: rtl/pvt_skew_pkg.sv
// ============================================================================
// Module      : pvt_skew_pkg
// Description : Shared types and constants for the skew-sensor readout path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pvt_skew_pkg;

  localparam int CODE_W_DEF = 7;
  localparam int GLITCH_SAT = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_DONE   = 2'd3
  } skew_state_e;

endpackage

`default_nettype wire

// File: rtl/skew_stab_filter.sv
// ============================================================================
// Module      : skew_stab_filter
// Description : Previous-code register and equality compare; a code is only
//               trusted when it matches the code of the preceding cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skew_stab_filter #(
  parameter int CODE_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_active,
  input  logic              i_prime,
  input  logic [CODE_W-1:0] i_code,
  output logic              o_accept,
  output logic              o_reject
);

  logic [CODE_W-1:0] r_prev;
  logic              w_match;
  logic              w_judge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '0;
    end else if (i_active) begin
      r_prev <= i_code;
    end
  end

  // The prime cycle only seeds r_prev, so it is neither accepted nor rejected.
  assign w_judge  = i_active && !i_prime;
  assign w_match  = (i_code == r_prev);
  assign o_accept = w_judge && w_match;
  assign o_reject = w_judge && !w_match;

endmodule

`default_nettype wire

// File: rtl/skew_code_reader.sv
// ============================================================================
// Module      : skew_code_reader
// Description : Collects 2^LOG2_SAMPLES skew codes per start request and
//               reports min/max/avg; stability filter enabled by the macro
//               SKEW_READER_GLITCH_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skew_code_reader
  import pvt_skew_pkg::*;
#(
  parameter int CODE_W        = CODE_W_DEF,
  parameter int LOG2_SAMPLES  = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CODE_W-1:0] code_in,
  output logic              busy,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [CODE_W-1:0] min_code,
  output logic [CODE_W-1:0] max_code,
  output logic [CODE_W-1:0] avg_code,
  output logic [7:0]        glitch_cnt,
  output logic              timeout
);

  localparam int c_sum_w    = CODE_W + LOG2_SAMPLES;
  localparam int c_settle_w = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [c_settle_w-1:0]   c_settle_last = c_settle_w'(SETTLE_CYCLES - 1);
  localparam logic [LOG2_SAMPLES:0]   c_last_sample = (LOG2_SAMPLES + 1)'((1 << LOG2_SAMPLES) - 1);

  skew_state_e             r_state;
  skew_state_e             w_state_next;
  logic [c_settle_w-1:0]   r_settle_cnt;
  logic                    r_prime;
  logic [c_sum_w-1:0]      r_sum;
  logic [c_sum_w-1:0]      w_sum_next;
  logic [LOG2_SAMPLES:0]   r_count;
  logic [CODE_W-1:0]       r_min;
  logic [CODE_W-1:0]       r_max;
  logic [CODE_W-1:0]       r_avg;
  logic                    w_accum;
  logic                    w_meas_start;
  logic                    w_accept;
  logic                    w_sat;
  logic                    w_fill_done;

  assign w_accum      = (r_state == ST_ACCUM);
  assign w_meas_start = (r_state == ST_IDLE) && start;
  assign w_sum_next   = r_sum + {{LOG2_SAMPLES{1'b0}}, code_in};
  assign w_fill_done  = w_accept && (r_count == c_last_sample);

`ifdef SKEW_READER_GLITCH_FILTER_EN
  logic       w_reject;
  logic [7:0] r_glitch;
  logic       r_timeout;

  skew_stab_filter #(
    .CODE_W (CODE_W)
  ) u_stab_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_active (w_accum),
    .i_prime  (r_prime),
    .i_code   (code_in),
    .o_accept (w_accept),
    .o_reject (w_reject)
  );

  assign w_sat = w_reject && (r_glitch == 8'(GLITCH_SAT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_glitch  <= '0;
      r_timeout <= 1'b0;
    end else if (w_meas_start) begin
      r_glitch  <= '0;
      r_timeout <= 1'b0;
    end else if (w_reject) begin
      r_glitch <= r_glitch + 1'b1;
      if (w_sat) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign glitch_cnt = r_glitch;
  assign timeout    = r_timeout;
`else
  assign w_accept   = w_accum && !r_prime;
  assign w_sat      = 1'b0;
  assign glitch_cnt = '0;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_next = ST_SETTLE;
      ST_SETTLE: if (r_settle_cnt == c_settle_last) w_state_next = ST_ACCUM;
      ST_ACCUM:  if (w_fill_done || w_sat) w_state_next = ST_DONE;
      ST_DONE:   if (result_ready) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Outputs decode the state register only, so nothing flows from inputs.
  always_comb begin
    busy         = 1'b0;
    result_valid = 1'b0;
    case (r_state)
      ST_SETTLE: busy = 1'b1;
      ST_ACCUM:  busy = 1'b1;
      ST_DONE:   result_valid = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle_cnt <= '0;
      r_prime      <= 1'b0;
      r_sum        <= '0;
      r_count      <= '0;
      r_min        <= '0;
      r_max        <= '0;
      r_avg        <= '0;
    end else begin
      if (w_meas_start) begin
        r_settle_cnt <= '0;
        r_sum        <= '0;
        r_count      <= '0;
        r_min        <= '1;
        r_max        <= '0;
      end
      if (r_state == ST_SETTLE) begin
        r_settle_cnt <= r_settle_cnt + 1'b1;
        r_prime      <= 1'b1;
      end
      if (w_accum) begin
        r_prime <= 1'b0;
      end
      if (w_accept) begin
        r_sum   <= w_sum_next;
        r_count <= r_count + 1'b1;
        if (code_in < r_min) r_min <= code_in;
        if (code_in > r_max) r_max <= code_in;
      end
      if (w_fill_done) begin
        r_avg <= w_sum_next[c_sum_w-1:LOG2_SAMPLES];
      end else if (w_sat) begin
        r_avg <= '0;
      end
    end
  end

  assign min_code = r_min;
  assign max_code = r_max;
  assign avg_code = r_avg;

endmodule

`default_nettype wire

// File: tb/tb_skew_code_reader.sv
// ============================================================================
// Module      : tb_skew_code_reader
// Description : Randomised scoreboard bench for skew_code_reader; the model
//               follows SKEW_READER_GLITCH_FILTER_EN like the design does.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_skew_code_reader;

  localparam int CW    = 7;
  localparam int L2    = 4;
  localparam int SC    = 4;
  localparam int NS    = 1 << L2;
  localparam int MAXC  = 1024;
  localparam int BOUND = 3000;

  typedef struct {
    logic [CW-1:0] mn;
    logic [CW-1:0] mx;
    logic [CW-1:0] av;
    logic [7:0]    gl;
    logic          to;
    int            lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          result_ready = 1'b0;
  logic [CW-1:0] code_in = '0;
  logic          busy;
  logic          result_valid;
  logic [CW-1:0] min_code;
  logic [CW-1:0] max_code;
  logic [CW-1:0] avg_code;
  logic [7:0]    glitch_cnt;
  logic          timeout;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   codes [MAXC];
  exp_t q[$];

  skew_code_reader #(
    .CODE_W        (CW),
    .LOG2_SAMPLES  (L2),
    .SETTLE_CYCLES (SC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .code_in      (code_in),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .min_code     (min_code),
    .max_code     (max_code),
    .avg_code     (avg_code),
    .glitch_cnt   (glitch_cnt),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic int code_at(input int k);
    return codes[(k < MAXC) ? k : MAXC - 1];
  endfunction

  // Walks the code sequence as seen from the cycle start is sampled (index 0):
  // SC settle cycles, one prime cycle, then sample until full or saturated.
  function automatic exp_t model();
    exp_t e;
    int prev, c, sum, cnt, g, mn, mx;
    bit acc;
    sum = 0; cnt = 0; g = 0; mn = (1 << CW) - 1; mx = 0;
    e.mn = '0; e.mx = '0; e.av = '0; e.gl = '0; e.to = 1'b0; e.lat = -1;
    prev = code_at(SC + 1);
    for (int k = SC + 2; k < BOUND; k++) begin
      c = code_at(k);
`ifdef SKEW_READER_GLITCH_FILTER_EN
      acc = (c == prev);
`else
      acc = 1'b1;
`endif
      prev = c;
      if (acc) begin
        sum += c;
        cnt++;
        if (c < mn) mn = c;
        if (c > mx) mx = c;
        if (cnt == NS) begin
          e.mn = CW'(mn); e.mx = CW'(mx); e.av = CW'(sum / NS);
          e.gl = 8'(g); e.to = 1'b0; e.lat = k;
          return e;
        end
      end else begin
        g++;
        if (g == 255) begin
          e.mn = CW'(mn); e.mx = CW'(mx); e.av = '0;
          e.gl = 8'd255; e.to = 1'b1; e.lat = k;
          return e;
        end
      end
    end
    return e;
  endfunction

  // Monitor: pops an expectation on each rising result_valid, then checks the
  // fields on every cycle valid stays high.
  bit   prev_v = 1'b0;
  bit   prev_b = 1'b0;
  bit   have = 1'b0;
  int   busy_cyc = 0;
  exp_t cur;

  always @(negedge clk) begin
    if (result_valid && !prev_v) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: result_valid rose with no request pending (t=%0t)", $time);
        have = 1'b0;
      end else begin
        cur  = q.pop_front();
        have = 1'b1;
        check("latency", 32'(cyc - busy_cyc), 32'(cur.lat));
      end
    end
    if (result_valid && have) begin
      check("min_code", 32'(min_code), 32'(cur.mn));
      check("max_code", 32'(max_code), 32'(cur.mx));
      check("avg_code", 32'(avg_code), 32'(cur.av));
      check("glitch_cnt", 32'(glitch_cnt), 32'(cur.gl));
      check("timeout", 32'(timeout), 32'(cur.to));
    end
    if (!result_valid) have = 1'b0;
    if (busy && !prev_b) busy_cyc = cyc;
    prev_v = result_valid;
    prev_b = busy;
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(result_valid), 32'd0);
    check({tag, "_min"}, 32'(min_code), 32'd0);
    check({tag, "_max"}, 32'(max_code), 32'd0);
    check({tag, "_avg"}, 32'(avg_code), 32'd0);
    check({tag, "_glitch"}, 32'(glitch_cnt), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_meas(input int hold, input bit pulse);
    exp_t e;
    int   k;
    e = model();
    q.push_back(e);
    code_in = CW'(code_at(0));
    start   = 1'b1;
    k       = 0;
    @(posedge clk); #1;
    start = 1'b0;
    while (!result_valid && k < BOUND) begin
      k++;
      code_in = CW'(code_at(k));
      @(posedge clk); #1;
    end
    if (!result_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_result: no result_valid within %0d cycles", BOUND);
      void'(q.pop_back());
      do_reset();
      return;
    end
    for (int i = 0; i < hold; i++) begin
      start = pulse;
      @(posedge clk); #1;
      start = 1'b0;
      check("done_start_ignored", 32'(busy), 32'd0);
    end
    result_ready = 1'b1;
    start        = pulse;
    @(posedge clk); #1;
    result_ready = 1'b0;
    start        = 1'b0;
    check("idle_valid", 32'(result_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_min_hold", 32'(min_code), 32'(e.mn));
    check("idle_max_hold", 32'(max_code), 32'(e.mx));
    check("idle_avg_hold", 32'(avg_code), 32'(e.av));
    @(posedge clk); #1;
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < MAXC; i++) codes[i] = v;
  endtask

  initial begin
    int h, v, i;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    fill_const(37);
    run_meas(0, 1'b0);

    for (int k = 0; k < MAXC; k++) begin
      v = 10 + ((k > SC + 1) ? (k - (SC + 1)) / 2 : 0);
      codes[k] = (v > 25) ? 25 : v;
    end
    run_meas(10, 1'b1);

    for (int k = 0; k < MAXC; k++) codes[k] = 10 + (k % 2);
    run_meas(2, 1'b1);

    fill_const(64);
    run_meas(0, 1'b0);
    fill_const(127);
    run_meas(1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      i = 0;
      while (i < MAXC) begin
        v = $urandom_range(127, 0);
        h = $urandom_range(4, 1);
        for (int j = 0; j < h && i < MAXC; j++) begin
          codes[i] = v;
          i++;
        end
      end
      run_meas($urandom_range(3, 0), 1'($urandom_range(1, 0)));
    end

    fill_const(50);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (SC + 4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1 check("post_reset_busy", 32'(busy), 32'd0);

    fill_const(37);
    run_meas(0, 1'b0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
